// File: rtl/trb_in_demux.sv
// -----------------------------------------------------------------------------
// trb_in_demux
//
// Ingress distributor for the turbo decoder array. A single upstream byte
// stream carrying fixed-length turbo frames is split into NUM_TURBO decoder
// input streams. Every frame goes whole to one decoder, and decoders are
// chosen round-robin. A decoder that is not ready when its turn comes is
// skipped. The output sop/eop markers are rebuilt from a beat counter, so
// every output frame is exactly FRAME_LEN beats long. The upstream sop/eop
// markers are only checked, and a mismatch raises an error pulse.
//
// Handshake: an upstream beat is accepted in any cycle where
// st_valid_in & st_ready_out is high. st_ready_out is combinational and
// mirrors st_ready_in of the selected decoder while a frame is in flight.
// The decoder ready inputs have a ready latency of 1. A beat accepted in
// cycle N is presented to the decoder in cycle N+1. st_valid_out is never
// raised without a matching accept in the previous cycle.
//
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   st_data_in    upstream data (DATA_W)
//   st_valid_in   upstream valid
//   st_sop_in     upstream start of packet (checked only)
//   st_eop_in     upstream end of packet (checked only)
//   st_ready_out  upstream ready (combinational)
//   st_ready_in   per-decoder ready (NUM_TURBO)
//   st_data_out   per-decoder data; channel k at [k*DATA_W +: DATA_W]
//   st_valid_out  per-decoder valid
//   st_sop_out    per-decoder sop (beat 0 of the output frame)
//   st_eop_out    per-decoder eop (beat FRAME_LEN-1 of the output frame)
//   cur_chan      selected channel, zero-extended to 4 bits
//   err_sop       one-cycle pulse: st_sop_in disagreed with beat position
//   err_len       one-cycle pulse: st_eop_in disagreed with beat position
// -----------------------------------------------------------------------------
module trb_in_demux #(
    parameter int NUM_TURBO = 2,
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 128
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             st_data_in,
    input  logic                          st_valid_in,
    input  logic                          st_sop_in,
    input  logic                          st_eop_in,
    output logic                          st_ready_out,
    input  logic [NUM_TURBO-1:0]          st_ready_in,
    output logic [NUM_TURBO*DATA_W-1:0]   st_data_out,
    output logic [NUM_TURBO-1:0]          st_valid_out,
    output logic [NUM_TURBO-1:0]          st_sop_out,
    output logic [NUM_TURBO-1:0]          st_eop_out,
    output logic [3:0]                    cur_chan,
    output logic                          err_sop,
    output logic                          err_len
);

    // -------------------------------------------------------------------------
    // Widths and constants
    // -------------------------------------------------------------------------
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int PTR_W = (NUM_TURBO > 1) ? $clog2(NUM_TURBO) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_TURBO - 1);

    // IDLE: look for the next decoder to take a frame. The search examines one
    //       channel per cycle, and upstream is held off while it runs.
    // XFER: a frame is streaming to decoder 'sel'.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr,   ptr_nxt;     // next channel to examine
    logic [PTR_W-1:0] sel,   sel_nxt;     // channel owning the current frame
    logic [CNT_W-1:0] cnt,   cnt_nxt;     // accepted beats of current frame

    logic                 accept;
    logic                 cnt_first;
    logic                 cnt_last;
    logic [NUM_TURBO-1:0] chan_hit;       // one-hot: accepted beat goes here

    // Round-robin successor. For the non-power-of-two channel counts the
    // explicit wrap keeps the pointer inside 0..NUM_TURBO-1. With a single
    // channel the pointer stays at 0.
    function automatic logic [PTR_W-1:0] next_chan(input logic [PTR_W-1:0] c);
        return (c == PTR_LAST) ? '0 : c + PTR_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Upstream handshake
    // -------------------------------------------------------------------------
    assign st_ready_out = (state == ST_XFER) & st_ready_in[sel];
    assign accept       = st_valid_in & st_ready_out;

    assign cnt_first    = (cnt == '0);
    assign cnt_last     = (cnt == CNT_LAST);

    assign cur_chan     = 4'(sel);

    always_comb begin
        chan_hit = '0;
        for (int k = 0; k < NUM_TURBO; k++) begin
            chan_hit[k] = accept & (sel == PTR_W'(k));
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        cnt_nxt   = cnt;

        case (state)
            ST_IDLE: begin
                if (st_ready_in[ptr]) begin
                    state_nxt = ST_XFER;
                    sel_nxt   = ptr;
                    cnt_nxt   = '0;
                end else begin
                    ptr_nxt   = next_chan(ptr);
                end
            end

            ST_XFER: begin
                // A bubble or a stalled decoder leaves the counter untouched.
                if (accept) begin
                    if (cnt_last) begin
                        // The frame is complete. The search for the next
                        // frame resumes after the decoder that was just
                        // served, so IDLE always takes at least one cycle.
                        state_nxt = ST_IDLE;
                        cnt_nxt   = '0;
                        ptr_nxt   = next_chan(sel);
                    end else begin
                        cnt_nxt   = cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output register: forwarded beat plus regenerated framing. The framing
    // checks are registered alongside, so an error pulse lines up with the
    // output beat that caused it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_data_out  <= '0;
            st_valid_out <= '0;
            st_sop_out   <= '0;
            st_eop_out   <= '0;
            err_sop      <= 1'b0;
            err_len      <= 1'b0;
        end else begin
            st_valid_out <= chan_hit;
            st_sop_out   <= cnt_first ? chan_hit : '0;
            st_eop_out   <= cnt_last  ? chan_hit : '0;

            // Data of idle channels holds its last value.
            for (int k = 0; k < NUM_TURBO; k++) begin
                if (chan_hit[k]) begin
                    st_data_out[k*DATA_W +: DATA_W] <= st_data_in;
                end
            end

            // The checks look only at accepted beats. They never change what
            // is forwarded.
            err_sop <= accept & (st_sop_in != cnt_first);
            err_len <= accept & (st_eop_in != cnt_last);
        end
    end

endmodule

// File: tb/tb_trb_in_demux.sv
// -----------------------------------------------------------------------------
// tb_trb_in_demux
//
// Bench for trb_in_demux with NUM_TURBO=2, DATA_W=8 and FRAME_LEN=128.
// A reference model advances once per cycle on the falling edge. It tracks
// which decoder owns the current frame, the round-robin candidate and the
// beat index. From these it derives the expected upstream ready. For each
// accepted beat it pushes the expected output word, including channel, sop,
// eop, error flags and arrival cycle, into exp_q. A separate monitor pops
// exp_q whenever a decoder valid is seen and compares the two.
// -----------------------------------------------------------------------------
module tb_trb_in_demux;

  localparam int NUM_TURBO = 2;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 128;
  localparam int BUDGET    = 3000;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic [DATA_W-1:0]           st_data_in = '0;
  logic                        st_valid_in = 1'b0;
  logic                        st_sop_in = 1'b0;
  logic                        st_eop_in = 1'b0;
  logic                        st_ready_out;
  logic [NUM_TURBO-1:0]        st_ready_in = '0;
  logic [NUM_TURBO*DATA_W-1:0] st_data_out;
  logic [NUM_TURBO-1:0]        st_valid_out;
  logic [NUM_TURBO-1:0]        st_sop_out;
  logic [NUM_TURBO-1:0]        st_eop_out;
  logic [3:0]                  cur_chan;
  logic                        err_sop;
  logic                        err_len;

  always #5 clk = ~clk;

  trb_in_demux #(
    .NUM_TURBO(NUM_TURBO),
    .DATA_W   (DATA_W),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st_data_in  (st_data_in),
    .st_valid_in (st_valid_in),
    .st_sop_in   (st_sop_in),
    .st_eop_in   (st_eop_in),
    .st_ready_out(st_ready_out),
    .st_ready_in (st_ready_in),
    .st_data_out (st_data_out),
    .st_valid_out(st_valid_out),
    .st_sop_out  (st_sop_out),
    .st_eop_out  (st_eop_out),
    .cur_chan    (cur_chan),
    .err_sop     (err_sop),
    .err_len     (err_len)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;

  // Layout: {cycle[15:0], chan[3:0], err_len, err_sop, eop, sop, data[7:0]}
  logic [31:0] exp_q[$];

  int beats_ch[NUM_TURBO];
  int err_sop_cnt  = 0;
  int err_len_cnt  = 0;
  int last_sop_ch  = -1;

  logic [NUM_TURBO-1:0] rdy_base = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one step per cycle, evaluated while inputs are stable
  // ---------------------------------------------------------------------------
  bit m_busy = 1'b0;
  int m_ptr  = 0;
  int m_sel  = 0;
  int m_beat = 0;

  always @(negedge clk) begin : model
    bit exp_rdy;
    bit e_sop;
    bit e_eop;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_sel  = 0;
      m_beat = 0;
      exp_q.delete();
    end else begin
      exp_rdy = m_busy && st_ready_in[m_sel];
      check("cur_chan", 32'(cur_chan), 32'(m_sel));
      check("st_ready_out", 32'(st_ready_out), 32'(exp_rdy));
      if (m_busy) begin
        if (exp_rdy && st_valid_in) begin
          e_sop = (m_beat == 0);
          e_eop = (m_beat == FRAME_LEN - 1);
          exp_q.push_back({16'(cyc + 1), 4'(m_sel), (st_eop_in != e_eop),
                           (st_sop_in != e_sop), e_eop, e_sop, st_data_in});
          if (e_eop) begin
            m_busy = 1'b0;
            m_ptr  = (m_sel + 1) % NUM_TURBO;
            m_beat = 0;
          end else begin
            m_beat++;
          end
        end
      end else if (st_ready_in[m_ptr]) begin
        m_busy = 1'b1;
        m_sel  = m_ptr;
        m_beat = 0;
      end else begin
        m_ptr = (m_ptr + 1) % NUM_TURBO;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compares every presented output beat with the head of exp_q
  // ---------------------------------------------------------------------------
  always begin : monitor
    logic [31:0] act;
    @(posedge clk);
    #2;
    check("valid_onehot0", 32'($onehot0(st_valid_out)), 32'd1);
    if (st_valid_out == '0) begin
      check("idle_flags", 32'({st_sop_out, st_eop_out, err_sop, err_len}), 32'd0);
    end
    err_sop_cnt += int'(err_sop);
    err_len_cnt += int'(err_len);
    for (int k = 0; k < NUM_TURBO; k++) begin
      if (st_valid_out[k]) begin
        act = {16'(cyc), 4'(k), err_len, err_sop, st_eop_out[k], st_sop_out[k],
               st_data_out[k*DATA_W +: DATA_W]};
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=0x%0h expected=none cycle=%0d", act, cyc);
        end else begin
          check("beat", act, exp_q.pop_front());
        end
        beats_ch[k]++;
        if (st_sop_out[k]) last_sop_ch = k;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    st_valid_in = 1'b0;
    st_ready_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Let the last accepted beat reach the monitor while the decoders are idle.
  task automatic drain();
    @(posedge clk);
    #1;
    st_valid_in = 1'b0;
    st_ready_in = '0;
    @(posedge clk);
    #3;
  endtask

  // Offers one frame of FRAME_LEN beats. eop_at: beat flagged with eop.
  // no_sop: drop sop on beat 0. drop_at: ch0 ready low for 5 cycles there.
  // rst_at: assert reset once that many beats are in. rnd: random ready,
  // bubbles, data and occasional sop/eop flips.
  task automatic send_frame(input int eop_at, input bit no_sop, input int drop_at,
                            input int rst_at, input bit rnd);
    int b = 0;
    int guard = 0;
    int drop_left = 0;
    bit dropped = 1'b0;
    bit in_drop;
    logic [NUM_TURBO-1:0] r;
    bit fs;
    bit fe;
    while (b < FRAME_LEN) begin
      @(posedge clk);
      #1;
      if (b == rst_at) begin
        rst_n       = 1'b0;
        st_valid_in = 1'b0;
        @(posedge clk);
        #2;
        check("rst_valid", 32'(st_valid_out), 32'd0);
        check("rst_sop_eop", 32'({st_sop_out, st_eop_out}), 32'd0);
        check("rst_cur_chan", 32'(cur_chan), 32'd0);
        check("rst_err", 32'({err_sop, err_len}), 32'd0);
        st_ready_in = '1;
        rst_n       = 1'b1;
        return;
      end
      if (b == drop_at && !dropped) begin
        drop_left = 5;
        dropped   = 1'b1;
      end
      if (rnd) begin
        for (int k = 0; k < NUM_TURBO; k++) r[k] = ($urandom_range(0, 3) != 0);
      end else begin
        r = rdy_base;
      end
      in_drop = (drop_left > 0);
      if (in_drop) begin
        r[0] = 1'b0;
        drop_left--;
      end
      fs = rnd && ($urandom_range(0, 19) == 0);
      fe = rnd && ($urandom_range(0, 19) == 0);
      st_ready_in = r;
      st_valid_in = rnd ? ($urandom_range(0, 4) != 0) : 1'b1;
      st_data_in  = rnd ? DATA_W'($urandom) : DATA_W'(b);
      st_sop_in   = ((b == 0) && !no_sop) ^ fs;
      st_eop_in   = (b == eop_at) ^ fe;
      @(negedge clk);
      if (in_drop) check("drop_ready_low", 32'(st_ready_out), 32'd0);
      if (st_valid_in && st_ready_out) b++;
      guard++;
      if (guard > BUDGET) begin
        checks++;
        failures++;
        $display("FAIL frame_timeout actual_beats=%0d required_beats=%0d", b, FRAME_LEN);
        return;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int b0;
    int b1;
    int es0;
    int el0;
    int n;
    foreach (beats_ch[k]) beats_ch[k] = 0;

    // Reset state. Decoders ready, yet upstream must stay held off in IDLE.
    st_ready_in = '1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_valid", 32'(st_valid_out), 32'd0);
    check("reset_sop_eop", 32'({st_sop_out, st_eop_out}), 32'd0);
    check("reset_data", 32'(st_data_out), 32'd0);
    check("reset_err", 32'({err_sop, err_len}), 32'd0);
    check("reset_cur_chan", 32'(cur_chan), 32'd0);
    check("reset_ready_out", 32'(st_ready_out), 32'd0);
    #1;
    rst_n = 1'b1;

    // Two back-to-back well-formed frames, both decoders ready.
    rdy_base = 2'b11;
    send_frame(FRAME_LEN - 1, 1'b0, -1, -1, 1'b0);
    send_frame(FRAME_LEN - 1, 1'b0, -1, -1, 1'b0);
    @(posedge clk);
    #2;
    check("ptr_after_two_frames", 32'(dut.ptr), 32'd0);
    drain();
    check("t1_beats_ch0", 32'(beats_ch[0]), 32'(FRAME_LEN));
    check("t1_beats_ch1", 32'(beats_ch[1]), 32'(FRAME_LEN));
    check("t1_err_sop", 32'(err_sop_cnt), 32'd0);
    check("t1_err_len", 32'(err_len_cnt), 32'd0);

    // Only ch1 ready at the frame start, then the next frame goes to ch0.
    do_reset();
    b0 = beats_ch[0];
    b1 = beats_ch[1];
    rdy_base = 2'b10;
    send_frame(FRAME_LEN - 1, 1'b0, -1, -1, 1'b0);
    rdy_base = 2'b11;
    send_frame(FRAME_LEN - 1, 1'b0, -1, -1, 1'b0);
    drain();
    check("t2_beats_ch1", 32'(beats_ch[1] - b1), 32'(FRAME_LEN));
    check("t2_beats_ch0", 32'(beats_ch[0] - b0), 32'(FRAME_LEN));

    // ch0 ready drops for 5 cycles at beat 40.
    do_reset();
    b0 = beats_ch[0];
    rdy_base = 2'b01;
    send_frame(FRAME_LEN - 1, 1'b0, 40, -1, 1'b0);
    drain();
    check("t3_beats_ch0", 32'(beats_ch[0] - b0), 32'(FRAME_LEN));

    // Malformed input: early eop at beat 99, then a frame without sop.
    do_reset();
    es0 = err_sop_cnt;
    el0 = err_len_cnt;
    rdy_base = 2'b11;
    send_frame(99, 1'b0, -1, -1, 1'b0);
    send_frame(FRAME_LEN - 1, 1'b1, -1, -1, 1'b0);
    drain();
    check("t4_err_len_pulses", 32'(err_len_cnt - el0), 32'd2);
    check("t4_err_sop_pulses", 32'(err_sop_cnt - es0), 32'd1);

    // Reset at beat 60 of a ch1 frame. The next frame restarts on ch0.
    do_reset();
    rdy_base = 2'b10;
    send_frame(FRAME_LEN - 1, 1'b0, -1, 60, 1'b0);
    rdy_base = 2'b11;
    send_frame(FRAME_LEN - 1, 1'b0, -1, -1, 1'b0);
    drain();
    check("t5_restart_sop_ch", 32'(last_sop_ch), 32'd0);

    // No decoder ready for 10 cycles, then ch1 comes up.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      st_ready_in = '0;
      @(negedge clk);
      check("stall_ready_low", 32'(st_ready_out), 32'd0);
    end
    @(posedge clk);
    #1;
    st_ready_in = 2'b10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!st_ready_out && n < 10);
    check("stall_start_within_2", 32'(n <= 2), 32'd1);
    b1 = beats_ch[1];
    rdy_base = 2'b10;
    send_frame(FRAME_LEN - 1, 1'b0, -1, -1, 1'b0);
    drain();
    check("t6_beats_ch1", 32'(beats_ch[1] - b1), 32'(FRAME_LEN));

    // Randomized frames: random ready, bubbles, data and framing flips.
    do_reset();
    for (int f = 0; f < 8; f++) begin
      send_frame(FRAME_LEN - 1, 1'b0, -1, -1, 1'b1);
    end
    drain();
    repeat (2) @(posedge clk);
    #3;
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
